i2c_reg_sequencer: RTL
======================

Name: i2c_reg_sequencer

Overview:
- Register-level controller that sequences the byte-level i2c_master handshake (transfer_start / transfer_continues / mode / data_tx / interrupt).
- Shares one i2c_master between NUM_REQ requesters, e.g. the PMIC status poller and the HDMI/MIPI config loaders.
- Each request is one complete register transaction: either a single-byte write, or a single-byte read using a repeated START.
- Round-robin arbitration between requesters. Optional automatic retry when the target NACKs.

Parameters:
- NUM_REQ, 2, number of requester ports (1..8).
- MAX_RETRY, 3, retries after a NACK/error before reporting failure (used only with the optional feature).

Ports:
- clk_in  input  1  system clock; same clock as i2c_master.
- RESETn  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request; held high until that requester's done pulse.
- req_write  input  NUM_REQ  1 = register write, 0 = register read.
- req_dev  input  7*NUM_REQ  7-bit device address, slice i = [7i+6:7i].
- req_reg  input  8*NUM_REQ  register address.
- req_wdata  input  8*NUM_REQ  write data.
- done  output  NUM_REQ  one-cycle completion pulse for the granted requester.
- err  output  1  valid with done: transaction failed.
- rdata  output  8  valid with done on a successful read.
- busy  output  1  transaction in progress.
- transfer_ready  input  1  from i2c_master.
- interrupt, transaction_complete, nack, start_err, arbitration_err  input  1 each  from i2c_master.
- data_rx  input  8  from i2c_master.
- transfer_start, transfer_continues, mode  output  1 each  to i2c_master.
- data_tx  output  8  to i2c_master.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
- All outputs are registered.
- "evt" = interrupt && (transaction_complete || start_err || arbitration_err).
- "bad" = evt && (start_err || arbitration_err || (nack && state != RDATA)).
- IDLE:
  - Leaves IDLE only when transfer_ready && |req.
  - Grant = first requester with req set, searching from last+1 with wrap; latch the grant index.
  - Same edge: transfer_start=1, transfer_continues=1, mode=0, data_tx={dev,0}, busy=1, go to ADDR_W.
  - Latency: 1 cycle from req (with transfer_ready high) to transfer_start.
- ADDR_W, on evt && !bad: transfer_start=0, transfer_continues = write ? 1 : 0, data_tx=reg; go to REG.
- REG, on evt && !bad:
  - Write: transfer_continues=0, data_tx=wdata; go to WDATA.
  - Read: transfer_start=1, transfer_continues=1, data_tx={dev,1}; go to ADDR_R (repeated START).
- WDATA, on evt && !bad: go to FINISH, err=0.
- ADDR_R, on evt && !bad: transfer_start=0, transfer_continues=0, mode=1; go to RDATA.
- RDATA, on evt: the master NACKs the last byte, so nack=1 is expected.
  - Capture rdata <= data_rx; go to FINISH, err=0.
  - start_err or arbitration_err here counts as bad.
- Any state, on bad:
  - transfer_start=0, transfer_continues=0, mode=0, err=1; go to WAIT_IDLE.
  - Remain in WAIT_IDLE until transfer_ready=1, then go to FINISH.
- FINISH: done[grant]=1 for exactly one cycle; busy=0; last=grant; mode=0; go to IDLE.
- A new grant cannot occur on the done cycle; the earliest is the next cycle.
- Requester fields are sampled only at the grant edge; changes after that are ignored.
- Deasserting req mid-transaction does not abort it; done is still pulsed.
- A bad event in WDATA means the master has already issued STOP; the controller still waits for transfer_ready.
- evt with no pending transaction (IDLE or FINISH) is ignored.
- rdata holds its last value until the next successful read.
- Reset mid-transaction: immediate return to reset values, no done pulse; the bus is recovered by i2c_master.

Optional Feature:
- Macro I2C_SEQ_RETRY_EN.
- Defined:
  - A 2-bit-minimum retry counter clears at grant.
  - On bad: if the count < MAX_RETRY, increment it, go through WAIT_IDLE, then restart at ADDR_W with the same latched request, err not set.
  - Otherwise set err=1 and finish as normal.
- Not defined: no counter; the first bad finishes with err=1.

Test Plan:
- Write: req0, write=1, dev=0x6B, reg=0x01, wdata=0x1B, slave ACKs all.
  - data_tx sequence 0xD6, 0x01, 0x1B; continues 1, 1, 0.
  - done[0] pulse, err=0.
- Read: req1, write=0, dev=0x6B, reg=0x08, slave returns 0x64.
  - data_tx sequence 0xD6, 0x08, 0xD7; start=1 on 0xD6 and 0xD7; mode=1 in RDATA.
  - done[1] with rdata=0x64, err=0.
- Arbitration: req0 and req1 asserted in the same cycle from reset and held.
  - Order req0, req1, req0, req1; a new grant is never issued on a done cycle.
- Address NACK: dev=0x20 with no slave present, macro off.
  - After ADDR_W: start=0, continues=0; wait for transfer_ready.
  - done with err=1; no REG byte is sent.
- Retry: macro on, MAX_RETRY=3, slave NACKs the first two address attempts then ACKs.
  - Three ADDR_W starts, then a normal read; done with err=0.
  - Slave always NACKs: four attempts, then err=1.
- Reset: assert RESETn=0 during RDATA.
  - All outputs 0 immediately; no done pulse; next request is granted to requester 0.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_reg_sequencer
//
// Register-level front end for a byte-level i2c_master. Several requesters
// (status pollers, config loaders, ...) share one master; each request is a
// complete register transaction:
//   write : START {dev,W} reg wdata STOP
//   read  : START {dev,W} reg  Sr {dev,R} <rdata, master NACK> STOP
// Requesters are served round-robin. The sequencer drives the master's
// transfer_start / transfer_continues / mode / data_tx controls and advances
// on each byte-complete interrupt.
//
// Optional feature (compile-time macro I2C_SEQ_RETRY_EN):
//   defined   - a failed transaction (NACK, start or arbitration error) is
//               retried from the address phase up to MAX_RETRY times before
//               being reported with err.
//   undefined - the first failure finishes the transaction with err.
//
// Ports
//   clk_in, RESETn         clock (shared with i2c_master), async active-low reset
//   req[i]                 request, held until done[i]
//   req_write[i]           1 = register write, 0 = register read
//   req_dev[7i+6:7i]       7-bit device address
//   req_reg[8i+7:8i]       register address
//   req_wdata[8i+7:8i]     write data
//   done[i]                one-cycle completion pulse for the granted requester
//   err                    valid with done: transaction failed
//   rdata                  valid with done on a successful read
//   busy                   transaction in progress
//   transfer_ready, interrupt, transaction_complete, nack, start_err,
//   arbitration_err, data_rx                     status from i2c_master
//   transfer_start, transfer_continues, mode, data_tx   controls to i2c_master
// ---------------------------------------------------------------------------
module i2c_reg_sequencer #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk_in,
    input  logic                 RESETn,
    // requester side
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_write,
    input  logic [7*NUM_REQ-1:0] req_dev,
    input  logic [8*NUM_REQ-1:0] req_reg,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic [7:0]           rdata,
    output logic                 busy,
    // i2c_master side
    input  logic                 transfer_ready,
    input  logic                 interrupt,
    input  logic                 transaction_complete,
    input  logic                 nack,
    input  logic                 start_err,
    input  logic                 arbitration_err,
    input  logic [7:0]           data_rx,
    output logic                 transfer_start,
    output logic                 transfer_continues,
    output logic                 mode,
    output logic [7:0]           data_tx
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

`ifdef I2C_SEQ_RETRY_EN
    localparam int CNT_W = (MAX_RETRY < 3) ? 2 : $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] RETRY_LIM = CNT_W'(MAX_RETRY);
`endif

    typedef enum logic [2:0] {
        IDLE,
        ADDR_W,
        REG,
        WDATA,
        ADDR_R,
        RDATA,
        WAIT_IDLE,
        FINISH
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] grant;

    // request fields latched at grant; later changes on the inputs are ignored
    logic             cur_write;
    logic [6:0]       cur_dev;
    logic [7:0]       cur_reg;
    logic [7:0]       cur_wdata;

`ifdef I2C_SEQ_RETRY_EN
    logic [CNT_W-1:0] retry_cnt;
    logic             retry_pend;   // WAIT_IDLE should restart, not finish
`endif

    // -----------------------------------------------------------------------
    // Per-requester field views
    // -----------------------------------------------------------------------
    logic [6:0] dev_a   [NUM_REQ];
    logic [7:0] reg_a   [NUM_REQ];
    logic [7:0] wdata_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign dev_a[i]   = req_dev[7*i +: 7];
        assign reg_a[i]   = req_reg[8*i +: 8];
        assign wdata_a[i] = req_wdata[8*i +: 8];
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: first requester with req set, searching from last+1
    // and wrapping, so the most recently served requester ranks lowest.
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             pick_vld;

    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!pick_vld && req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Master event decode
    // -----------------------------------------------------------------------
    logic evt;
    logic bad;
    logic in_xfer;

    assign evt = interrupt && (transaction_complete || start_err || arbitration_err);
    // The read data byte is always NACKed by the master itself, so nack only
    // signals a failure outside RDATA.
    assign bad = evt && (start_err || arbitration_err || (nack && (state != RDATA)));
    // Events are only meaningful while a byte is on the bus for us.
    assign in_xfer = (state == ADDR_W) || (state == REG) || (state == WDATA) ||
                     (state == ADDR_R) || (state == RDATA);

    // -----------------------------------------------------------------------
    // Sequencer FSM, all outputs registered
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge RESETn) begin
        if (!RESETn) begin
            state              <= IDLE;
            last               <= LAST_RST;
            grant              <= '0;
            cur_write          <= 1'b0;
            cur_dev            <= '0;
            cur_reg            <= '0;
            cur_wdata          <= '0;
            done               <= '0;
            err                <= 1'b0;
            rdata              <= '0;
            busy               <= 1'b0;
            transfer_start     <= 1'b0;
            transfer_continues <= 1'b0;
            mode               <= 1'b0;
            data_tx            <= '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_cnt          <= '0;
            retry_pend         <= 1'b0;
`endif
        end else begin
            done <= '0;

            if (in_xfer && bad) begin
                // Master has stopped (or will); release the bus controls and
                // wait for it to report ready before finishing or retrying.
                transfer_start     <= 1'b0;
                transfer_continues <= 1'b0;
                mode               <= 1'b0;
                state              <= WAIT_IDLE;
`ifdef I2C_SEQ_RETRY_EN
                if (retry_cnt < RETRY_LIM) begin
                    retry_cnt  <= retry_cnt + 1'b1;
                    retry_pend <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
`else
                err <= 1'b1;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        // done != 0 marks the completion cycle: no grant there,
                        // giving the finished requester time to drop req.
                        if (transfer_ready && pick_vld && (done == '0)) begin
                            grant              <= pick;
                            cur_write          <= req_write[pick];
                            cur_dev            <= dev_a[pick];
                            cur_reg            <= reg_a[pick];
                            cur_wdata          <= wdata_a[pick];
                            transfer_start     <= 1'b1;
                            transfer_continues <= 1'b1;
                            mode               <= 1'b0;
                            data_tx            <= {dev_a[pick], 1'b0};
                            busy               <= 1'b1;
                            err                <= 1'b0;
                            state              <= ADDR_W;
`ifdef I2C_SEQ_RETRY_EN
                            retry_cnt          <= '0;
                            retry_pend         <= 1'b0;
`endif
                        end
                    end

                    ADDR_W: begin
                        if (evt) begin
                            // A read ends the write phase after the register
                            // byte; the repeated START follows.
                            transfer_start     <= 1'b0;
                            transfer_continues <= cur_write;
                            data_tx            <= cur_reg;
                            state              <= REG;
                        end
                    end

                    REG: begin
                        if (evt) begin
                            if (cur_write) begin
                                transfer_continues <= 1'b0;
                                data_tx            <= cur_wdata;
                                state              <= WDATA;
                            end else begin
                                transfer_start     <= 1'b1;
                                transfer_continues <= 1'b1;
                                data_tx            <= {cur_dev, 1'b1};
                                state              <= ADDR_R;
                            end
                        end
                    end

                    WDATA: begin
                        if (evt) begin
                            err   <= 1'b0;
                            state <= FINISH;
                        end
                    end

                    ADDR_R: begin
                        if (evt) begin
                            // single byte read: last byte, master NACKs + STOPs
                            transfer_start     <= 1'b0;
                            transfer_continues <= 1'b0;
                            mode               <= 1'b1;
                            state              <= RDATA;
                        end
                    end

                    RDATA: begin
                        if (evt) begin
                            rdata <= data_rx;
                            err   <= 1'b0;
                            state <= FINISH;
                        end
                    end

                    WAIT_IDLE: begin
                        if (transfer_ready) begin
`ifdef I2C_SEQ_RETRY_EN
                            if (retry_pend) begin
                                // replay the latched request from the address byte
                                retry_pend         <= 1'b0;
                                transfer_start     <= 1'b1;
                                transfer_continues <= 1'b1;
                                mode               <= 1'b0;
                                data_tx            <= {cur_dev, 1'b0};
                                state              <= ADDR_W;
                            end else begin
                                state <= FINISH;
                            end
`else
                            state <= FINISH;
`endif
                        end
                    end

                    FINISH: begin
                        done  <= NUM_REQ'(1) << grant;
                        busy  <= 1'b0;
                        last  <= grant;
                        mode  <= 1'b0;
                        state <= IDLE;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
